reg_dump_sequencer: RTL
=======================

Name: reg_dump_sequencer

Overview:
Debug/monitor sequencer that walks the 64-bit, 32-entry CPU register file through its monitor read-select port and streams the contents out as a byte stream.
Output uses a valid/ready handshake toward a UART/VGA text sink.
Sits beside the register file and drives its monitor select input, so CPU read/write ports are never touched.
Each register is latched atomically before serialization, so a concurrent CPU write cannot tear a 64-bit value.

Parameters:
FIRST_REG, 0, first register index dumped (0..31).
LAST_REG, 31, last register index dumped; FIRST_REG <= LAST_REG <= 31 is required.
SEND_INDEX, 1, 1 = prefix each register with an index byte {3'b000, idx}; 0 = data bytes only.

Ports:
iCLK  in  1  system clock; all state updates on posedge.
iRST  in  1  reset.
iStart  in  1  start-dump request, sampled in IDLE only.
iAbort  in  1  synchronous abort of a dump in progress.
oRegSelect  out  5  register index driven to the register file monitor select.
iRegData  in  64  monitor read data, combinational from oRegSelect.
oTxData  out  8  stream byte.
oTxValid  out  1  oTxData valid.
iTxReady  in  1  sink accepts the byte.
oBusy  out  1  dump in progress.
oDone  out  1  one-cycle pulse when a dump completes normally.

Behaviour:
- Reset iRST is asynchronous, active-high. While asserted and on release:
  - FSM = IDLE, oRegSelect = FIRST_REG, oTxData = 8'h00.
  - oTxValid = 0, oBusy = 0, oDone = 0.
  - Shadow register, beat counter and index are all 0 (index = FIRST_REG).
- States: IDLE, SEL, LATCH, SEND, DONE (encoding from the shared package).
- IDLE:
  - iStart = 1 -> SEL, idx <= FIRST_REG, oBusy <= 1.
  - iStart while not IDLE is ignored; no queuing.
- SEL:
  - oRegSelect = idx; one settle cycle -> LATCH.
- LATCH:
  - shadow <= iRegData (whole 64 bits in one edge).
  - beat <= 0 if SEND_INDEX else 1.
  - -> SEND with oTxValid = 1.
- SEND:
  - Beat 0 = index byte. Beats 1..8 = shadow bytes, little-endian: beat k carries shadow[8k-1 -: 8], so beat 1 = bits 7:0.
  - oTxData and oTxValid hold stable until a posedge with oTxValid & iTxReady.
  - Handshake on beat < 8: beat + 1, oTxValid stays 1, no bubble.
  - Handshake on beat 8 with idx != LAST_REG: oTxValid <= 0, idx <= idx + 1, -> SEL.
  - Handshake on beat 8 with idx == LAST_REG: oTxValid <= 0, -> DONE.
- DONE:
  - oDone = 1 and oBusy = 0 for exactly this cycle, then -> IDLE.
- Latency and throughput:
  - iStart to first oTxValid = 2 cycles (SEL, LATCH).
  - With iTxReady held high: 11 cycles per register with SEND_INDEX=1, 10 with SEND_INDEX=0.
  - Full default dump = 32*11 = 352 cycles, plus the DONE cycle.
- iAbort:
  - In any non-IDLE state, next state = IDLE.
  - oTxValid <= 0 immediately; an unaccepted byte is dropped (the only permitted valid withdrawal).
  - oBusy <= 0; no oDone.
  - iAbort in IDLE has no effect. iAbort has priority over a same-cycle handshake.
- Simultaneous iStart and iAbort in IDLE: start wins.
- Index arithmetic is 5-bit; idx never wraps because termination compares against LAST_REG.
- Register 31 (zero register) is dumped as whatever the file returns (0).
- Asserting iRST mid-dump aborts silently: outputs return to reset values asynchronously, no oDone.
- oRegSelect holds its last value in IDLE and DONE.

Decomposition:
- Shared package: FSM state encoding, BYTES_PER_REG = 8, INDEX_BYTE_PAD = 3'b000.
- Sub-module dump_byte_serializer (shift/mux of shadow by beat, valid/ready hold logic) is natural. The FSM and index counter stay in the top.

Test Plan:
- Reset values: assert iRST mid-SEND -> oTxValid, oBusy, oDone all 0 and oRegSelect = 0 within the same cycle, asynchronous to iCLK.
- Full dump, iTxReady = 1, model iRegData = {32'hDEADBEEF, 27'h0, sel} -> 288 bytes. Register 5 frame = 05, 05,00,00,00, EF,BE,AD,DE. oDone pulses once at cycle 353 after iStart.
- Backpressure: toggle iTxReady 1,0,0,1 randomly -> byte sequence identical to the no-stall run; oTxData never changes while oTxValid=1 and iTxReady=0.
- Tear protection: change the model's register 3 value from 64'h1111 to 64'h2222 during register 3's SEND -> all 8 bytes come from 64'h1111.
- Range and format: FIRST_REG=28, LAST_REG=30, SEND_INDEX=0 -> exactly 24 bytes, oRegSelect visits 28, 29, 30; no index bytes.
- Abort: iAbort during beat 4 of register 10 -> next cycle oTxValid=0, oBusy=0, no oDone. A new iStart restarts from FIRST_REG.

Source files
------------

// File: rtl/reg_dump_sequencer_pkg.sv
// Shared definitions for the register-file dump sequencer: FSM encoding and
// byte-stream framing constants.
package reg_dump_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int         BYTES_PER_REG  = 8;
  localparam logic [2:0] INDEX_BYTE_PAD = 3'b000;

endpackage

// File: rtl/reg_dump_sequencer_serializer.sv
// Holds the atomically latched register value and turns it into a framed
// byte stream: optional index byte, then eight data bytes, LSB first.
module dump_byte_serializer
  import reg_dump_sequencer_pkg::*;
#(
  parameter int SEND_INDEX = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        active,
  input  logic        abort,
  input  logic        tx_ready,
  input  logic [63:0] reg_data,
  input  logic [4:0]  reg_index,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        accept,
  output logic        last_beat
);

  localparam logic [3:0] FIRST_BEAT = (SEND_INDEX != 0) ? 4'd0 : 4'd1;

  logic [63:0] shadow;
  logic [3:0]  beat;
  logic [2:0]  byte_sel;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      beat   <= '0;
    end else if (load) begin
      shadow <= reg_data;
      beat   <= FIRST_BEAT;
    end else if (accept && !last_beat) begin
      beat <= beat + 4'd1;
    end
  end

  // Data beats 1..8 map to byte lanes 0..7; beat 8 wraps to lane 7.
  assign byte_sel = beat[2:0] - 3'd1;

  // NOTE: tx_data gets its default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_data = 8'h00;
    if (active) begin
      if (beat == 4'd0) tx_data = {INDEX_BYTE_PAD, reg_index};
      else              tx_data = shadow[{byte_sel, 3'b000} +: 8];
    end
  end

  assign tx_valid  = active;
  assign accept    = active & tx_ready & ~abort;
  assign last_beat = (beat == 4'(BYTES_PER_REG));

endmodule

// File: rtl/reg_dump_sequencer.sv
// Walks the register file through its monitor select port and streams each
// register out as bytes over a valid/ready handshake.
module reg_dump_sequencer
  import reg_dump_sequencer_pkg::*;
#(
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31,
  parameter int SEND_INDEX = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iAbort,
  output logic [4:0]  oRegSelect,
  input  logic [63:0] iRegData,
  output logic [7:0]  oTxData,
  output logic        oTxValid,
  input  logic        iTxReady,
  output logic        oBusy,
  output logic        oDone
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t     state, state_next;
  logic [4:0] idx;
  logic       accept, last_beat;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_IDLE;
      idx   <= FIRST_IDX;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && iStart)
        idx <= FIRST_IDX;
      else if (state == ST_SEND && accept && last_beat && idx != LAST_IDX)
        idx <= idx + 5'd1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (iStart) state_next = ST_SEL;
      ST_SEL:   state_next = ST_LATCH;
      ST_LATCH: state_next = ST_SEND;
      ST_SEND:  if (accept && last_beat)
                  state_next = (idx == LAST_IDX) ? ST_DONE : ST_SEL;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle final handshake.
    if (iAbort && state != ST_IDLE) state_next = ST_IDLE;
  end

  dump_byte_serializer #(
    .SEND_INDEX(SEND_INDEX)
  ) u_serializer (
    .clk      (iCLK),
    .rst      (iRST),
    .load     (state == ST_LATCH),
    .active   (state == ST_SEND),
    .abort    (iAbort),
    .tx_ready (iTxReady),
    .reg_data (iRegData),
    .reg_index(idx),
    .tx_data  (oTxData),
    .tx_valid (oTxValid),
    .accept   (accept),
    .last_beat(last_beat)
  );

  assign oRegSelect = idx;
  assign oBusy      = (state == ST_SEL) || (state == ST_LATCH) || (state == ST_SEND);
  assign oDone      = (state == ST_DONE);

endmodule
